sm_switch_capture: RTL
======================

# sm_switch_capture

Debounced, synchronised capture of the board's raw switch bank, feeding the processor's external-data input (`extData` of `sm_top`). It is the input-direction counterpart of the register-to-7-segment display path. It presents a stable switch word plus a sticky "changed" flag and per-bit change mask, which the consumer clears with a one-cycle acknowledge.

## Interface
Parameters:
- `WIDTH`, 8: number of switch inputs.
- `DEBOUNCE_CYCLES`, 500000: cycles a new input value must hold before being committed (10 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: counter width, derived and not overridden.

Ports:
- `clkIn` in 1: system clock (50 MHz on board).
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in WIDTH: raw switch levels, asynchronous to `clkIn`.
- `extData` out WIDTH: debounced, committed switch word.
- `chg_valid` out 1: sticky flag, set when `extData` changes.
- `chg_mask` out WIDTH: OR of all bits that changed since the last acknowledge.
- `chg_ack` in 1: one-cycle pulse that clears `chg_valid` and `chg_mask`.

## Operation
- Each bit of `sw` passes through a 2-flop synchroniser, giving `sw_s`.
- A single shared debounce path holds a `cand` register and a counter `cnt`.
- State machine `st`, with two states:
  - STABLE: `cand == sw_s`, and `cnt` is saturated at `DEBOUNCE_CYCLES-1`. If `sw_s != cand`, then `cand <= sw_s`, `cnt <= 0`, and the machine goes to SETTLE.
  - SETTLE: if `sw_s != cand`, then `cand <= sw_s` and `cnt <= 0`, and the machine stays in SETTLE; any bounce restarts the whole window. Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, commit and go to STABLE. Otherwise `cnt <= cnt+1`.
- On commit, when `cand != extData`:
  - `extData <= cand`
  - `chg_mask <= chg_mask | (cand ^ extData)`
  - `chg_valid <= 1`
- On commit, when `cand == extData` (the input bounced back to its old value), there is no flag and no mask change.
- `chg_ack` clears `chg_valid` and `chg_mask` on the next edge.
- Commit and `chg_ack` on the same edge: the commit wins. The result is `chg_valid = 1` and `chg_mask = cand ^ extData_old`, with old bits discarded.
- `chg_ack` while `chg_valid = 0` has no effect.
- Reset values (asynchronous): `extData = 0`, `chg_valid = 0`, `chg_mask = 0`, synchronisers = 0, `cand = 0`, `cnt = 0`, `st` = STABLE.
  - A non-zero `sw` at reset release therefore produces a normal commit after the debounce window.
- Reset asserted mid-SETTLE discards `cand`/`cnt` immediately. No partial commit occurs.

## Timing
- Let edge k be the first `clkIn` edge sampling a new `sw` value.
  - `sw_s` is valid after edge k+1.
  - `cand` loads at edge k+2, with `cnt = 0`.
  - Commit occurs at edge k+2+`DEBOUNCE_CYCLES`, provided `sw_s` holds.
  - `extData`, `chg_valid` and `chg_mask` update together on that edge.
- A pulse on `sw_s` shorter than `DEBOUNCE_CYCLES` cycles is never committed.
- `chg_ack` takes effect one edge after it is sampled high. It is level-sampled, so holding it high simply keeps clearing.
- All outputs are registered, with no combinational path from any input.

## Configuration
- Macro `SM_SWITCH_DEBOUNCE_EN`.
- Defined: the debounce FSM and counter exist as described above.
- Undefined: no counter and no FSM. Commit occurs every cycle from `sw_s`, so `extData` updates at edge k+2. Flag and mask semantics and the ack/commit priority are unchanged. This mode is for fast simulation of `sm_top` programs.

## Structure
- Package `sm_switch_pkg`:
  - state typedef `sm_switch_state_t` {STABLE, SETTLE}
  - default `DEBOUNCE_CYCLES` constant
  - `SYNC_STAGES = 2` constant
- Sub-module `sm_sync2`: a WIDTH-parameterised 2-flop synchroniser with async active-low reset to 0, instantiated once.
- The board top replaces its direct switch concatenation with `extData` from this block.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 4` and the macro defined, unless noted.
- Reset with `sw = 0xA5`, release: outputs are 0 during reset. At edge 6 after release, `extData = 0xA5`, `chg_valid = 1`, `chg_mask = 0xA5`.
- Pulse `chg_ack` one cycle: the next edge gives `chg_valid = 0`, `chg_mask = 0x00`, and `extData` stays `0xA5`.
- Glitch: from `extData = 0x00`, drive `sw = 0x01` for 3 cycles then back to `0x00`. Result: no commit; `chg_valid` stays 0 and `extData` stays `0x00`.
- Bounce: toggle `sw[0]` every 2 cycles for 12 cycles, then hold at 1. Result: exactly one commit, 4+2 edges after the final toggle, with `extData = 0x01` and `chg_mask = 0x01`.
- Accumulate, then collide:
  - Commit `0x01`, then `0x81`, with no ack: `chg_mask = 0x81`.
  - Then assert `chg_ack` on the same edge as the commit of `0x80`: `chg_valid = 1`, `chg_mask = 0x01`.
- Macro undefined: a step on `sw` to `0x3C` appears on `extData` at edge k+2, with `chg_valid = 1`. Asserting reset one cycle after the step clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/sm_switch_pkg.sv
// Shared types and constants for the switch-bank capture path.
package sm_switch_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } sm_switch_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SYNC_STAGES             = 2;

endpackage

// File: rtl/sm_sync2.sv
// WIDTH-bit two-flop synchroniser for asynchronous level inputs, reset to zero.
module sm_sync2 import sm_switch_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Metastability chain: first stage samples the raw level, last stage is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sm_switch_capture.sv
// Debounced switch capture with sticky change flag/mask cleared by chg_ack.
// Macro SM_SWITCH_DEBOUNCE_EN enables the debounce FSM; otherwise sw_s commits every cycle.
module sm_switch_capture import sm_switch_pkg::*; #(
  parameter  int WIDTH           = 8,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] extData,
  output logic             chg_valid,
  output logic [WIDTH-1:0] chg_mask,
  input  logic             chg_ack
);

  if (DEBOUNCE_CYCLES < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("sm_switch_capture: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] sw_s;
  logic [WIDTH-1:0] commit_word_s;
  logic             commit_s;

  sm_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk_i  (clkIn),
    .rst_ni (rst_n),
    .d_i    (sw),
    .q_o    (sw_s)
  );

`ifdef SM_SWITCH_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  sm_switch_state_t st_q, st_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= STABLE;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any difference between sw_s and cand restarts the whole settle window.
  always_comb begin
    st_d     = st_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (st_q)
      STABLE: begin
        if (sw_s != cand_q) begin
          cand_d = sw_s;
          cnt_d  = '0;
          st_d   = SETTLE;
        end else begin
          st_d = STABLE;
        end
      end
      SETTLE: begin
        if (sw_s != cand_q) begin
          cand_d = sw_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          commit_s = 1'b1;
          st_d     = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        st_d   = STABLE;
        cand_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  assign commit_word_s = cand_q;
`else
  assign commit_s      = 1'b1;
  assign commit_word_s = sw_s;
`endif

  logic [WIDTH-1:0] ext_q, ext_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  // A value-changing commit beats a simultaneous ack; the ack then only drops older bits.
  always_comb begin
    ext_d   = ext_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (commit_s && (commit_word_s != ext_q)) begin
      ext_d   = commit_word_s;
      valid_d = 1'b1;
      if (chg_ack) begin
        mask_d = commit_word_s ^ ext_q;
      end else begin
        mask_d = mask_q | (commit_word_s ^ ext_q);
      end
    end else if (chg_ack) begin
      mask_d  = '0;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign extData   = ext_q;
  assign chg_mask  = mask_q;
  assign chg_valid = valid_q;

endmodule
